// File: rtl/rv_skid.sv
// Fully registered valid/ready slice: a two-entry buffer (output register plus
// skid register) that cuts the combinational ready path between slave and master.
module rv_skid #(
  parameter int unsigned wd = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [wd-1:0] datain,
  input  logic          datain_val,
  output logic          datain_rdy,
  input  logic          dataout_rdy,
  output logic          dataout_val,
  output logic [wd-1:0] dataout,
  output logic [1:0]    count
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          next_state;
  logic [wd-1:0]   skid;

  logic            in_fire;
  logic            out_fire;
  logic            load_head;
  logic            head_from_skid;
  logic            load_skid;
  logic            next_val;
  logic            next_rdy;
  logic [CW-1:0]   next_count;

  // Handshakes as seen at the coming edge; both qualifiers are flop outputs.
  assign in_fire  = datain_val && datain_rdy;
  assign out_fire = dataout_val && dataout_rdy;

  // Next-state and datapath steering.
  always_comb begin
    next_state     = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          load_head  = 1'b1;
          next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (in_fire && out_fire) begin
          load_head = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          next_state = S_FULL;
        end else if (out_fire) begin
          next_state = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          load_head      = 1'b1;
          head_from_skid = 1'b1;
          next_state     = S_BUSY;
        end
      end
      default: next_state = S_EMPTY;
    endcase
  end

  // Registered flags derived from where the buffer is headed.
  always_comb begin
    next_val   = (next_state != S_EMPTY);
    next_rdy   = (next_state != S_FULL);
    next_count = CW'(0);
    unique case (next_state)
      S_BUSY:  next_count = CW'(1);
      S_FULL:  next_count = CW'(2);
      default: next_count = CW'(0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      dataout_val <= 1'b0;
      datain_rdy  <= 1'b0;
      count       <= CW'(0);
      dataout     <= wd'(0);
      skid        <= wd'(0);
    end else begin
      state_q     <= next_state;
      dataout_val <= next_val;
      datain_rdy  <= next_rdy;
      count       <= next_count;
      if (load_head) begin
        dataout <= head_from_skid ? skid : datain;
      end
      if (load_skid) begin
        skid <= datain;
      end
    end
  end

endmodule

// File: tb/tb_rv_skid.sv
// Bench for rv_skid: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rv_skid;

  localparam int unsigned WD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [WD-1:0] datain;
  logic          datain_val;
  logic          datain_rdy;
  logic          dataout_rdy;
  logic          dataout_val;
  logic [WD-1:0] dataout;
  logic [1:0]    count;

  int checks   = 0;
  int failures = 0;

  logic [WD-1:0] m_q[$];
  logic          m_rdy  = 1'b0;
  logic [WD-1:0] m_last = '0;
  logic [WD-1:0] delivered[$];
  logic          started = 1'b0;

  rv_skid #(.wd(WD)) dut (
    .clk        (clk),
    .rst        (rst),
    .datain     (datain),
    .datain_val (datain_val),
    .datain_rdy (datain_rdy),
    .dataout_rdy(dataout_rdy),
    .dataout_val(dataout_val),
    .dataout    (dataout),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a FIFO of at most two beats whose ready flag is the
  // previous cycle's "room left" decision.
  always @(posedge clk) begin
    logic          r, v, orr, pv, acc, tk;
    logic [WD-1:0] d, pd;
    r   = rst;
    v   = datain_val;
    d   = datain;
    orr = dataout_rdy;
    pv  = dataout_val;
    pd  = dataout;
    if (r) begin
      m_q.delete();
      m_rdy   = 1'b0;
      m_last  = '0;
      started = 1'b1;
    end else begin
      acc = v && m_rdy;
      tk  = (m_q.size() > 0) && orr;
      if (pv && orr) delivered.push_back(pd);
      if (tk) void'(m_q.pop_front());
      if (acc) m_q.push_back(d);
      m_rdy = (m_q.size() < 2);
      if (m_q.size() > 0) m_last = m_q[0];
    end
    #1;
    if (started) begin
      chk("val",   32'(dataout_val), 32'(m_q.size() != 0));
      chk("count", 32'(count),       32'(m_q.size()));
      chk("rdy",   32'(datain_rdy),  32'(m_rdy));
      chk("data",  32'(dataout),     32'((m_q.size() > 0) ? m_q[0] : m_last));
      if (!r && pv && !orr) chk("stall_hold", 32'(dataout), 32'(pd));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [WD-1:0] exp_abc[3];
    logic          pat[6];
    rst = 1'b1; datain_val = 1'b1; datain = 4'hF; dataout_rdy = 1'b0;
    tick(2);
    chk("rst_val",   32'(dataout_val), 32'd0);
    chk("rst_count", 32'(count),       32'd0);
    chk("rst_data",  32'(dataout),     32'd0);
    chk("rst_rdy",   32'(datain_rdy),  32'd0);
    rst = 1'b0; datain_val = 1'b0;
    tick();
    chk("rdy_after_rst", 32'(datain_rdy), 32'd1);

    // Streaming 1..F with the slave always ready.
    delivered.delete();
    dataout_rdy = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      datain = WD'(i); datain_val = 1'b1;
      tick();
      chk("stream_count", 32'(count), 32'd1);
    end
    datain_val = 1'b0;
    tick();
    chk("stream_len", 32'(delivered.size()), 32'd15);
    for (int i = 0; i < 15 && i < delivered.size(); i++)
      chk("stream_beat", 32'(delivered[i]), 32'(i + 1));
    chk("stream_empty", 32'(count), 32'd0);

    // Backpressure: A, B fill the buffer, C must wait.
    delivered.delete();
    dataout_rdy = 1'b0;
    datain = 4'hA; datain_val = 1'b1;
    tick();
    chk("bp_count1", 32'(count), 32'd1);
    chk("bp_headA",  32'(dataout), 32'hA);
    datain = 4'hB;
    tick();
    chk("bp_count2", 32'(count), 32'd2);
    chk("bp_rdy0",   32'(datain_rdy), 32'd0);
    datain = 4'hC;
    tick();
    chk("bp_holdA",  32'(dataout), 32'hA);
    chk("bp_count2b", 32'(count), 32'd2);
    dataout_rdy = 1'b1;
    tick();
    chk("bp_rdy1", 32'(datain_rdy), 32'd1);
    chk("bp_headB", 32'(dataout), 32'hB);
    tick();
    datain_val = 1'b0;
    tick();
    exp_abc = '{4'hA, 4'hB, 4'hC};
    chk("bp_len", 32'(delivered.size()), 32'd3);
    for (int i = 0; i < 3 && i < delivered.size(); i++)
      chk("bp_order", 32'(delivered[i]), 32'(exp_abc[i]));

    // Bubbles: valid alternates, slave always ready.
    delivered.delete();
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      datain_val = (i % 2 == 0) && (i < 5);
      datain     = WD'(5 + i / 2);
      tick();
      chk("bub_val",   32'(dataout_val), 32'(pat[i]));
      chk("bub_count", 32'(count),       32'(pat[i]));
    end
    chk("bub_len", 32'(delivered.size()), 32'd3);
    for (int i = 0; i < 3 && i < delivered.size(); i++)
      chk("bub_data", 32'(delivered[i]), 32'(5 + i));

    // Reset while full discards both entries.
    delivered.delete();
    dataout_rdy = 1'b0;
    datain = 4'h9; datain_val = 1'b1;
    tick();
    datain = 4'hA;
    tick();
    chk("mr_full", 32'(count), 32'd2);
    rst = 1'b1; datain_val = 1'b0;
    tick();
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_val",   32'(dataout_val), 32'd0);
    rst = 1'b0; dataout_rdy = 1'b1;
    tick();
    datain = 4'h3; datain_val = 1'b1;
    tick();
    datain_val = 1'b0;
    tick();
    chk("mr_len",   32'(delivered.size()), 32'd1);
    if (delivered.size() > 0) chk("mr_first", 32'(delivered[0]), 32'h3);

    // Random traffic; the per-cycle model compare does the checking.
    for (int i = 0; i < 10000; i++) begin
      datain      = WD'($urandom);
      datain_val  = ($urandom_range(0, 3) != 0);
      dataout_rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    datain_val = 1'b0; dataout_rdy = 1'b1;
    tick(3);
    chk("drain_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_skid.md
# rv_skid

Fully registered valid/ready slice for the backward (ready) direction. It breaks the combinational `dataout_rdy` → `datain_rdy` path, which the forward-only valid slice leaves combinational. It does this with a two-entry buffer (output register plus skid register), so `datain_rdy`, `dataout_val` and `dataout` are all driven straight from flops. It sits between a master and a slave on any `datain`/`dataout` handshake link whose ready path misses timing, and sustains one transfer per cycle.

## Interface
- `wd`, default 4: data width in bits.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `datain` input `wd`: data from the master.
- `datain_val` input 1: master valid.
- `datain_rdy` output 1: ready to the master. Registered.
- `dataout_rdy` input 1: slave ready.
- `dataout_val` output 1: valid to the slave. Registered.
- `dataout` output `wd`: data to the slave. Registered.
- `count` output 2: occupancy, 0..2. Registered.

## Operation
- Define `in = datain_val && datain_rdy` and `out = dataout_val && dataout_rdy`, both sampled at the rising edge.
- Storage:
  - Output register `dataout` holds the head entry.
  - Skid register `skid` holds the second entry.
  - Ordering is strict FIFO.
- States are EMPTY (count 0), BUSY (count 1, head in `dataout`) and FULL (count 2, head in `dataout`, second entry in `skid`).
- EMPTY:
  - On `in`: `dataout <= datain`, go to BUSY.
  - Otherwise: stay in EMPTY.
- BUSY:
  - `in && out`: `dataout <= datain`, stay in BUSY.
  - `in && !out`: `skid <= datain`, go to FULL.
  - `!in && out`: go to EMPTY.
  - Neither: hold.
- FULL:
  - `in` cannot occur because `datain_rdy` = 0.
  - On `out`: `dataout <= skid`, go to BUSY.
  - Otherwise: hold.
- Register updates:
  - `dataout_val <= (next_state != EMPTY)`.
  - `datain_rdy <= (next_state != FULL)`.
  - `count <= ` encoding of `next_state`.
- `dataout` holds its value whenever `dataout_val && !dataout_rdy`; it never changes while it is being offered and not taken.
- In EMPTY, `dataout` keeps the last value it held, and the slave must ignore it.
- `skid` is written only on the BUSY `in && !out` transition.
- No data is dropped or duplicated under any pattern of `datain_val` and `dataout_rdy`.

## Timing
- Reset, applied at the edge where `rst` = 1:
  - State EMPTY.
  - `dataout_val` = 0, `datain_rdy` = 0, `count` = 0.
  - `dataout` = 0, `skid` = 0.
- Inputs are ignored during any cycle with `rst` = 1.
- `datain_rdy` goes to 1 at the first edge with `rst` = 0, so it is low for exactly one cycle after reset is released.
- Latency: a beat accepted at edge N appears on `dataout` with `dataout_val` = 1 after edge N, i.e. one cycle.
- Throughput: 1 beat per cycle while `dataout_rdy` stays high; no bubbles.
- Backpressure:
  - `dataout_rdy` low with `in` occurring in BUSY: `datain_rdy` drops after that same edge.
  - The master sees ready low one cycle late. The skid register absorbs exactly that one extra beat.
- Release: in FULL, `dataout_rdy` high causes `datain_rdy` = 1 after the next edge, and the skid entry moves to `dataout` at that same edge.
- Simultaneous in and out in BUSY: count stays at 1 and data passes straight through.
- Reset mid-operation, from any state: all contents are discarded and the block returns to the reset values above.
- The block has no combinational path from any input to any output.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `datain_val` = 1.
  - Required: `dataout_val` = 0, `count` = 0, `dataout` = 0 and `datain_rdy` = 0 during reset.
  - Required: `datain_rdy` = 1 one cycle after `rst` falls.
- Streaming: `dataout_rdy` = 1, push 1, 2, 3, ..., F on consecutive cycles.
  - Required: the slave sees 1..F on consecutive cycles, each one cycle after acceptance.
  - Required: `count` = 1 throughout and `datain_rdy` stays 1.
- Backpressure: `dataout_rdy` = 0, push A then B.
  - Required: `count` goes 1 then 2, and `datain_rdy` = 0 after B is accepted.
  - Required: while stalled, `dataout` holds A and C is not accepted.
  - Then raise `dataout_rdy`. Required: the slave receives A, then B, then C in order; `datain_rdy` returns to 1 one cycle after A leaves.
- Bubbles: alternate `datain_val` 1/0 with data 5, 6, 7 and `dataout_rdy` = 1.
  - Required: `dataout_val` pattern 1, 0, 1, 0, 1 carrying 5, 6, 7.
  - Required: `count` toggles between 1 and 0.
- Mid-operation reset: fill to FULL with 9 and A, then assert `rst` for one cycle.
  - Required: `count` = 0 and `dataout_val` = 0; neither 9 nor A is ever delivered.
  - Required: the next push of 3 arrives as the first output.
- Random: random `datain_val` and `dataout_rdy` for 10k cycles.
  - Required: the output sequence equals the input sequence (scoreboard).
  - Required: `count` never exceeds 2, `dataout` is stable while stalled, and no beat is accepted while `datain_rdy` = 0.
